// File: rtl/mips_pkg.sv
// mips_pkg: state encodings, opcode/function constants and pc_src selects shared by the control path
package mips_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MULW   = 3'd5,
    S_TRAP   = 3'd7
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_MUL   = 6'b011100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FUNC_JR  = 6'b001000;
  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;
  localparam logic [1:0] PC_JR  = 2'd3;
  function automatic logic is_imm(input logic [5:0] o);
    return o == OP_ADDI || o == OP_SLTI || o == OP_ANDI || o == OP_ORI || o == OP_LUI;
  endfunction
  function automatic logic is_br(input logic [5:0] o);
    return o == OP_BEQ || o == OP_BNE;
  endfunction
  function automatic logic is_mem(input logic [5:0] o);
    return o == OP_LW || o == OP_SW;
  endfunction
endpackage

// File: rtl/mc_wait_cnt.sv
// mc_wait_cnt: counts stalled cycles and flags the cycle in which the wait would reach its limit
module mc_wait_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);
  logic [W-1:0] cnt;
  // number of stalled cycles since the last clear
  always_ff @(posedge clk)
    cnt <= (!rst_n || clr) ? '0 : en ? cnt + 1'b1 : cnt;
  assign expired = en && (cnt + 1'b1 == limit);
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS control FSM; define MC_CTRL_MUL_EN to add the MULW multiply-wait path
module mc_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TMO     = 15,
  parameter int MUL_LAT_MAX = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       mem_rdy,
  input  logic       mul_done,
  output logic       pc_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       mem_req,
  output logic       mem_wr,
  output logic       iord,
  output logic       alu_srcb_imm,
  output logic       reg_dst_rd,
  output logic       mem_to_reg,
  output logic       mul_start,
  output logic       br_eval,
  output logic       illegal,
  output logic       trap,
  output logic [1:0] pc_src,
  output logic [2:0] state
);
  state_t     st, st_n;
  logic       run, is_mul, legal, done, en, clr, expired;
  logic [7:0] limit;
`ifdef MC_CTRL_MUL_EN
  logic mul_first;
  assign is_mul = op == OP_MUL;
  assign done   = st == S_MULW ? mul_done : mem_rdy;
  assign limit  = st == S_MULW ? 8'(MUL_LAT_MAX) : 8'(MEM_TMO);
  // marks the first cycle after entering MULW so mul_start is a single pulse
  always_ff @(posedge clk)
    mul_first <= rst_n && st_n == S_MULW && st != S_MULW;
  assign mul_start = st == S_MULW && mul_first;
`else
  localparam int unused_lat = MUL_LAT_MAX;
  logic unused_mul_done;
  assign unused_mul_done = mul_done;
  assign is_mul    = 1'b0;
  assign done      = mem_rdy;
  assign limit     = 8'(MEM_TMO);
  assign mul_start = 1'b0;
`endif
  // run holds off the first fetch until one edge after reset is released
  assign legal = op == OP_RTYPE || op == OP_J || op == OP_JAL || is_imm(op) || is_br(op) || is_mem(op) || is_mul;
  assign en    = ((st == S_FETCH && run) || st == S_MEM || st == S_MULW) && !done;
  assign clr   = !run || st_n != st;
  assign state = st;
  mc_wait_cnt #(.W(8)) u_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .en      (en),
    .limit   (limit),
    .expired (expired)
  );
  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    st  <= rst_n ? st_n : S_FETCH;
    run <= rst_n;
  end
  // next-state selection
  always_comb begin
    st_n = st;
    case (st)
      S_FETCH:  st_n = !run ? S_FETCH : mem_rdy ? S_DECODE : expired ? S_TRAP : S_FETCH;
      S_DECODE: st_n = op == OP_RTYPE ? (func == FUNC_JR ? S_FETCH : S_EXEC) :
                       (is_imm(op) || is_br(op) || is_mem(op)) ? S_EXEC :
                       is_mul ? S_MULW : S_FETCH;
      S_EXEC:   st_n = is_br(op) ? S_FETCH : is_mem(op) ? S_MEM : S_WB;
      S_MEM:    st_n = mem_rdy ? (op == OP_SW ? S_FETCH : S_WB) : expired ? S_TRAP : S_MEM;
      S_WB:     st_n = S_FETCH;
`ifdef MC_CTRL_MUL_EN
      S_MULW:   st_n = mul_done ? S_WB : expired ? S_TRAP : S_MULW;
`endif
      S_TRAP:   st_n = S_TRAP;
      default:  st_n = S_FETCH;
    endcase
  end
  // Moore-style control outputs, with fetch completion qualified by mem_rdy
  always_comb begin
    pc_we        = 1'b0;
    ir_we        = 1'b0;
    reg_we       = 1'b0;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    iord         = 1'b0;
    alu_srcb_imm = 1'b0;
    reg_dst_rd   = 1'b0;
    mem_to_reg   = 1'b0;
    br_eval      = 1'b0;
    illegal      = 1'b0;
    trap         = 1'b0;
    pc_src       = PC_SEQ;
    case (st)
      S_FETCH: begin
        mem_req = run;
        ir_we   = run && mem_rdy;
        pc_we   = run && mem_rdy;
      end
      S_DECODE: begin
        pc_we   = op == OP_J || op == OP_JAL || (op == OP_RTYPE && func == FUNC_JR);
        pc_src  = (op == OP_J || op == OP_JAL) ? PC_JMP : (op == OP_RTYPE && func == FUNC_JR) ? PC_JR : PC_SEQ;
        reg_we  = op == OP_JAL;
        illegal = !legal;
      end
      S_EXEC: begin
        alu_srcb_imm = op != OP_RTYPE;
        br_eval      = is_br(op);
        pc_we        = is_br(op);
        pc_src       = is_br(op) ? PC_BR : PC_SEQ;
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_wr  = op == OP_SW;
      end
      S_WB: begin
        reg_we     = 1'b1;
        reg_dst_rd = op == OP_RTYPE || is_mul;
        mem_to_reg = op == OP_LW;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized instruction stream checked cycle by cycle against a per-instruction timeline model
module tb_mc_ctrl;
  localparam int MEM_TMO = 15;
  localparam int MUL_LAT_MAX = 33;
  localparam logic [12:0] PCWE = 13'h1000, IRWE = 13'h0800, REGWE = 13'h0400, MREQ = 13'h0200,
                          MWR = 13'h0100, IORD = 13'h0080, IMM = 13'h0040, RDST = 13'h0020,
                          M2R = 13'h0010, MSTART = 13'h0008, BREV = 13'h0004, ILL = 13'h0002,
                          TRAPF = 13'h0001;
  logic clk, rst_n, mem_rdy, mul_done;
  logic [5:0] op, func;
  logic pc_we, ir_we, reg_we, mem_req, mem_wr, iord, alu_srcb_imm, reg_dst_rd, mem_to_reg;
  logic mul_start, br_eval, illegal, trap;
  logic [1:0] pc_src;
  logic [2:0] state;
  logic [17:0] obs;
  typedef struct {
    logic [2:0]  st;
    logic [1:0]  ps;
    logic [12:0] f;
    logic        rdy;
    logic        md;
    logic [5:0]  o;
    logic [5:0]  fn;
  } ent_t;
  ent_t q[$];
  logic [5:0] cop, cfn;
  int total, bad;
  logic [5:0] ops[14] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b001000, 6'b001010,
                          6'b001100, 6'b001101, 6'b001111, 6'b100011, 6'b101011, 6'b011100, 6'b000000};
  logic [5:0] bad_ops[5] = '{6'b000001, 6'b000110, 6'b010000, 6'b111111, 6'b100000};

  mc_ctrl #(.MEM_TMO(MEM_TMO), .MUL_LAT_MAX(MUL_LAT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .mem_rdy(mem_rdy), .mul_done(mul_done),
    .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .mem_req(mem_req), .mem_wr(mem_wr), .iord(iord),
    .alu_srcb_imm(alu_srcb_imm), .reg_dst_rd(reg_dst_rd), .mem_to_reg(mem_to_reg),
    .mul_start(mul_start), .br_eval(br_eval), .illegal(illegal), .trap(trap),
    .pc_src(pc_src), .state(state)
  );
  assign obs = {state, pc_src, pc_we, ir_we, reg_we, mem_req, mem_wr, iord, alu_srcb_imm,
                reg_dst_rd, mem_to_reg, mul_start, br_eval, illegal, trap};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (state/pc_src/flags)", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [2:0] st, input logic [1:0] ps, input logic [12:0] f,
                      input logic rdy, input logic md);
    ent_t e;
    e = '{st, ps, f, rdy, md, cop, cfn};
    q.push_back(e);
  endtask

  task automatic trap_tail();
    for (int i = 0; i < 4; i++) push(3'd7, 2'd0, TRAPF, rb(), rb());
  endtask

  // expected per-cycle timeline of one instruction: fd fetch stalls, md memory/multiply stalls
  task automatic gen(input logic [5:0] o, input logic [5:0] fn, input int fd, input int md, input bit cut);
    logic [12:0] mf;
    cop = o;
    cfn = fn;
    for (int i = 0; i < fd && i < MEM_TMO; i++) push(3'd0, 2'd0, MREQ, 1'b0, rb());
    if (fd >= MEM_TMO) begin trap_tail(); return; end
    push(3'd0, 2'd0, MREQ | IRWE | PCWE, 1'b1, rb());
    if (o == 6'b000010) begin push(3'd1, 2'd2, PCWE, rb(), rb()); return; end
    if (o == 6'b000011) begin push(3'd1, 2'd2, PCWE | REGWE, rb(), rb()); return; end
    if (o == 6'b000000) begin
      if (fn == 6'b001000) begin push(3'd1, 2'd3, PCWE, rb(), rb()); return; end
      push(3'd1, 2'd0, 13'd0, rb(), rb());
      push(3'd2, 2'd0, 13'd0, rb(), rb());
      push(3'd4, 2'd0, REGWE | RDST, rb(), rb());
      return;
    end
    if (o inside {6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001111}) begin
      push(3'd1, 2'd0, 13'd0, rb(), rb());
      push(3'd2, 2'd0, IMM, rb(), rb());
      push(3'd4, 2'd0, REGWE, rb(), rb());
      return;
    end
    if (o == 6'b000100 || o == 6'b000101) begin
      push(3'd1, 2'd0, 13'd0, rb(), rb());
      push(3'd2, 2'd1, IMM | BREV | PCWE, rb(), rb());
      return;
    end
    if (o == 6'b100011 || o == 6'b101011) begin
      mf = (o == 6'b101011) ? MWR : 13'd0;
      push(3'd1, 2'd0, 13'd0, rb(), rb());
      push(3'd2, 2'd0, IMM, rb(), rb());
      for (int i = 0; i < md && i < MEM_TMO; i++) begin
        push(3'd3, 2'd0, MREQ | IORD | mf, 1'b0, rb());
        if (cut) return;
      end
      if (md >= MEM_TMO) begin trap_tail(); return; end
      push(3'd3, 2'd0, MREQ | IORD | mf, 1'b1, rb());
      if (o == 6'b100011) push(3'd4, 2'd0, REGWE | M2R, rb(), rb());
      return;
    end
`ifdef MC_CTRL_MUL_EN
    if (o == 6'b011100) begin
      push(3'd1, 2'd0, 13'd0, rb(), rb());
      for (int i = 0; i < md && i < MUL_LAT_MAX; i++) push(3'd5, 2'd0, i == 0 ? MSTART : 13'd0, rb(), 1'b0);
      if (md >= MUL_LAT_MAX) begin trap_tail(); return; end
      push(3'd5, 2'd0, md == 0 ? MSTART : 13'd0, rb(), 1'b1);
      push(3'd4, 2'd0, REGWE | RDST, rb(), rb());
      return;
    end
`endif
    push(3'd1, 2'd0, ILL, rb(), rb());
  endtask

  task automatic play(input string tag);
    ent_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      op = e.o;
      func = e.fn;
      mem_rdy = e.rdy;
      mul_done = e.md;
      #1;
      chk(tag, 32'(obs), 32'({e.st, e.ps, e.f}));
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    mem_rdy = rb();
    mul_done = rb();
    @(negedge clk);
    #1;
    chk({tag, "_rst"}, 32'(obs), 32'd0);
    rst_n = 1'b1;
    #1;
    chk({tag, "_rel"}, 32'(obs), 32'd0);
  endtask

  function automatic int pick_delay(input int lim);
    int r;
    r = $urandom_range(0, 9);
    return r == 0 ? lim - 1 : r < 4 ? 0 : int'($urandom_range(0, 4));
  endfunction

  initial begin
    logic [5:0] o, fn;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    op = 6'd0;
    func = 6'd0;
    mem_rdy = 1'b0;
    mul_done = 1'b0;
    do_reset("reset");
    gen(6'b000000, 6'b100000, 0, 0, 0);
    play("radd");
    gen(6'b100011, 6'b000000, 0, 3, 0);
    play("lw_d3");
    gen(6'b000011, 6'b000000, 0, 0, 0);
    play("jal");
    gen(6'b011100, 6'b000000, 0, 2, 0);
    play("mul");
    gen(6'b000000, 6'b001000, 2, 0, 0);
    play("jr");
    gen(6'b101011, 6'b000000, MEM_TMO - 1, MEM_TMO - 1, 0);
    play("sw_edge");
    for (int n = 0; n < 150; n++) begin
      o = $urandom_range(0, 5) == 0 ? bad_ops[$urandom_range(0, 4)] : ops[$urandom_range(0, 13)];
      fn = $urandom_range(0, 4) == 0 ? 6'b001000 : 6'($urandom_range(0, 63));
      gen(o, fn, pick_delay(MEM_TMO), o == 6'b011100 ? pick_delay(MUL_LAT_MAX) : pick_delay(MEM_TMO), 0);
      play("rand");
    end
    gen(6'b000000, 6'b100000, MEM_TMO, 0, 0);
    play("fetch_tmo");
    do_reset("after_ftmo");
    gen(6'b100011, 6'b000000, 1, MEM_TMO, 0);
    play("mem_tmo");
    do_reset("after_mtmo");
`ifdef MC_CTRL_MUL_EN
    gen(6'b011100, 6'b000000, 0, MUL_LAT_MAX, 0);
    play("mul_tmo");
    do_reset("after_multmo");
`endif
    gen(6'b101011, 6'b000000, 0, 6, 1);
    play("sw_cut");
    do_reset("sw_mid");
    gen(6'b001101, 6'b000000, 0, 0, 0);
    play("ori_post");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter MEM_TMO, default 15, means the maximum number of cycles a memory request may wait for mem_rdy before trapping (range 1..255).
REQ-002 Parameter MUL_LAT_MAX, default 33, means the maximum number of cycles MULW may wait for mul_done before trapping.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port op, input, 6 bits: decoded opcode, valid from DECODE onward.
REQ-006 Port func, input, 6 bits: decoded function field, valid from DECODE onward.
REQ-007 Port mem_rdy, input, 1 bit: memory completes the current request this cycle.
REQ-008 Port mul_done, input, 1 bit: the multiplier result is valid.
REQ-009 Outputs, each 1 bit: pc_we, ir_we, reg_we, mem_req, mem_wr, iord, alu_srcb_imm, reg_dst_rd, mem_to_reg, mul_start, br_eval, illegal, trap.
REQ-010 Output pc_src, 2 bits: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs (jr).
REQ-011 Output state, 3 bits: current FSM state, for debug.

Function
REQ-012 The FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MULW=5 and TRAP=7, held in a registered state with Moore outputs.
REQ-013 In FETCH the block SHALL assert mem_req with iord=0; on mem_rdy it SHALL pulse ir_we and pc_we with pc_src=0 and go to DECODE, otherwise stay in FETCH.
REQ-014 DECODE SHALL last exactly 1 cycle; j (000010) and jal (000011) SHALL pulse pc_we with pc_src=2 and go to FETCH, and jal SHALL also pulse reg_we.
REQ-015 From DECODE, R-type (000000) SHALL go to EXEC; jr (func 001000) SHALL pulse pc_we with pc_src=3 and go to FETCH.
REQ-016 From DECODE, lw (100011), sw (101011), addi/slti/andi/ori/lui (001000/001010/001100/001101/001111) and beq/bne (000100/000101) SHALL go to EXEC.
REQ-017 In EXEC alu_srcb_imm SHALL be 1 for all non-R-type instructions.
REQ-018 In EXEC, beq/bne SHALL assert br_eval and pc_src=1 and go to FETCH; the datapath gates pc_we with the compare result.
REQ-019 In EXEC, lw/sw SHALL go to MEM and all other instructions SHALL go to WB.
REQ-020 MEM SHALL assert mem_req with iord=1, plus mem_wr for sw.
REQ-021 On mem_rdy in MEM, lw SHALL go to WB and sw SHALL go to FETCH.
REQ-022 WB SHALL pulse reg_we for 1 cycle, with reg_dst_rd=1 for R-type/mul and mem_to_reg=1 for lw, then go to FETCH.
REQ-023 Cycle counts with mem_rdy asserted immediately SHALL be: R-type/imm = 4, lw = 5, sw = 4, branch = 3, j = 2.
REQ-024 A wait counter SHALL clear on entry to FETCH, MEM or MULW and increment each cycle mem_rdy/mul_done is low.
REQ-025 When the wait counter reaches MEM_TMO (or MUL_LAT_MAX in MULW) without completion, the FSM SHALL go to TRAP.
REQ-026 TRAP SHALL assert trap, keep all write enables at 0, and hold until reset.
REQ-027 An unlisted opcode in DECODE SHALL pulse illegal for 1 cycle and return to FETCH without any write.
REQ-028 mem_rdy arriving in the same cycle the counter hits its limit SHALL count as completion, with no trap.

Reset
REQ-029 While rst_n=0 at a clock edge, state SHALL become FETCH, the wait counter SHALL become 0, and all outputs SHALL be 0 except pc_src=0 and state=0.
REQ-030 Reset asserted mid-request SHALL abandon the request, and mem_req SHALL be low on the cycle after the reset edge.
REQ-031 After rst_n deasserts, FETCH SHALL assert mem_req on the next cycle.

Configuration
REQ-032 With MC_CTRL_MUL_EN defined, op 011100 SHALL go from DECODE to MULW, pulsing mul_start on the first MULW cycle, and go to WB on mul_done.
REQ-033 Without MC_CTRL_MUL_EN, op 011100 SHALL be treated as illegal per REQ-027, and MULW logic and the mul_start driver SHALL be absent, with mul_start tied 0.

Structure
REQ-034 The state encodings, opcode constants (OP_RTYPE, OP_MUL, OP_LW, ...), FUNC_JR and pc_src encodings SHALL live in the shared package mips_pkg.
REQ-035 The wait counter and its timeout compare SHALL be one sub-module, mc_wait_cnt (parameter width, clear, enable, limit -> expired).

Verification
REQ-036 After reset, with op=000000 func=100000 and mem_rdy=1 every cycle, states SHALL be 0,1,2,4,0, with reg_we=1 only in cycle 4 and reg_dst_rd=1.
REQ-037 With lw and mem_rdy delayed 3 cycles in MEM, MEM SHALL last 4 cycles, then WB with mem_to_reg=1 and reg_we=1.
REQ-038 With MEM_TMO=15 and mem_rdy held low in FETCH, trap SHALL become 1 after 15 cycles with state=7, and remain so until rst_n=0.
REQ-039 With op=000011 (jal), DECODE SHALL show pc_we=1, pc_src=2, reg_we=1, and the next state SHALL be FETCH.
REQ-040 With op=011100, with the macro the FSM SHALL reach MULW, give mul_start=1 for one cycle, and go to WB after mul_done; without the macro, illegal=1 and the next state is FETCH.
REQ-041 With rst_n=0 driven during MEM of a sw, the next cycle SHALL have state=0 and mem_req=0 and mem_wr=0.
